// File: rtl/simd_shift_ctrl.sv
// Two-pass sequencer around an external combinational SIMD shifter: shifts take one pass, rotates two.
// Rotate support (ROL/ROR) is built only when SIMD_SHIFT_CTRL_ROTATE_EN is defined.
module simd_shift_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [2:0]   cmd_mode,
  input  logic [255:0] cmd_a,
  input  logic [7:0]   cmd_amt,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [255:0] res_data,
  output logic         res_err,
  output logic         busy,
  output logic [255:0] sh_a,
  output logic [255:0] sh_b,
  output logic [2:0]   sh_mode,
  output logic [1:0]   sh_sel,
  output logic         sh_imm_flag,
  output logic [7:0]   sh_imm,
  input  logic [255:0] sh_out
);

  localparam logic [2:0] OP_SRL = 3'b000;
  localparam logic [2:0] OP_SRA = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, OUT} state_t;

  state_t         r_state;
  logic [2:0]     r_op;
  logic [2:0]     r_mode;
  logic [255:0]   r_a;
  logic [7:0]     r_amt;
  logic [255:0]   r_data;
  logic           r_err;
  logic           w_legal;
  logic [1:0]     w_p1_sel;

  always_comb begin
    w_legal = 1'b0;
    case (cmd_op)
      OP_SRL, OP_SRA, OP_SLL: w_legal = 1'b1;
`ifdef SIMD_SHIFT_CTRL_ROTATE_EN
      OP_ROL, OP_ROR:         w_legal = 1'b1;
`endif
      default:                w_legal = 1'b0;
    endcase
  end

  // Rotates reuse the shifter: ROL starts as a left shift, ROR as a logical right shift.
  always_comb begin
    w_p1_sel = 2'b00;
    case (r_op)
      OP_SRA:         w_p1_sel = 2'b01;
      OP_SLL, OP_ROL: w_p1_sel = 2'b11;
      default:        w_p1_sel = 2'b00;
    endcase
  end

`ifdef SIMD_SHIFT_CTRL_ROTATE_EN
  logic [255:0] r_part;
  logic [7:0]   w_mask;
  logic [7:0]   w_p2_imm;
  logic [1:0]   w_p2_sel;

  // Lane width is a power of two, so "mod w" is a mask and (w-n) mod w is -n masked.
  always_comb begin
    case (r_mode)
      3'd0:    w_mask = 8'h07;
      3'd1:    w_mask = 8'h0F;
      3'd2:    w_mask = 8'h1F;
      3'd3:    w_mask = 8'h3F;
      3'd4:    w_mask = 8'h7F;
      default: w_mask = 8'hFF;
    endcase
  end

  assign w_p2_imm = (8'd0 - (r_amt & w_mask)) & w_mask;
  assign w_p2_sel = (r_op == OP_ROL) ? 2'b00 : 2'b11;
`endif

  always_comb begin
    sh_a   = '0;
    sh_sel = 2'b10;
    sh_imm = '0;
    case (r_state)
      PASS1: begin
        sh_a   = r_a;
        sh_sel = w_p1_sel;
        sh_imm = r_amt;
      end
`ifdef SIMD_SHIFT_CTRL_ROTATE_EN
      PASS2: begin
        sh_a   = r_a;
        sh_sel = w_p2_sel;
        sh_imm = w_p2_imm;
      end
`endif
      default: ;
    endcase
  end

  assign sh_b        = '0;
  assign sh_mode     = r_mode;
  assign sh_imm_flag = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_mode  <= '0;
      r_a     <= '0;
      r_amt   <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
`ifdef SIMD_SHIFT_CTRL_ROTATE_EN
      r_part  <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (cmd_valid) begin
          r_op   <= cmd_op;
          r_mode <= cmd_mode;
          r_a    <= cmd_a;
          r_amt  <= cmd_amt;
          if (w_legal) begin
            r_state <= PASS1;
          end else begin
            r_data  <= '0;
            r_err   <= 1'b1;
            r_state <= OUT;
          end
        end
        PASS1: begin
`ifdef SIMD_SHIFT_CTRL_ROTATE_EN
          if (r_op == OP_ROL || r_op == OP_ROR) begin
            r_part  <= sh_out;
            r_state <= PASS2;
          end else
`endif
          begin
            r_data  <= sh_out;
            r_err   <= 1'b0;
            r_state <= OUT;
          end
        end
`ifdef SIMD_SHIFT_CTRL_ROTATE_EN
        PASS2: begin
          r_data  <= r_part | sh_out;
          r_err   <= 1'b0;
          r_state <= OUT;
        end
`endif
        OUT: if (res_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign res_valid = (r_state == OUT);
  assign res_data  = r_data;
  assign res_err   = r_err;

endmodule

// File: tb/tb_simd_shift_ctrl.sv
// Directed bench for simd_shift_ctrl with a behavioural per-lane shifter on the sh_* port.
// Expectations follow SIMD_SHIFT_CTRL_ROTATE_EN as seen at compile time.
module tb_simd_shift_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [2:0]   cmd_mode;
  logic [255:0] cmd_a;
  logic [7:0]   cmd_amt;
  logic         res_valid;
  logic         res_ready;
  logic [255:0] res_data;
  logic         res_err;
  logic         busy;
  logic [255:0] sh_a;
  logic [255:0] sh_b;
  logic [2:0]   sh_mode;
  logic [1:0]   sh_sel;
  logic         sh_imm_flag;
  logic [7:0]   sh_imm;
  logic [255:0] sh_out;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  simd_shift_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mode(cmd_mode), .cmd_a(cmd_a), .cmd_amt(cmd_amt),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .busy(busy), .sh_a(sh_a), .sh_b(sh_b), .sh_mode(sh_mode), .sh_sel(sh_sel),
    .sh_imm_flag(sh_imm_flag), .sh_imm(sh_imm), .sh_out(sh_out)
  );

  // Reference shifter: sel 00 SRL, 01 SRA, 11 SLL, 10 NOP (zero), per lane, amount mod lane width.
  function automatic logic [255:0] shift_model(input logic [255:0] a, input logic [2:0] mode,
                                               input logic [1:0] sel, input logic [7:0] imm);
    logic [255:0] o;
    int w, amt, pos, base;
    o = '0;
    w = (mode >= 3'd5) ? 256 : (8 << mode);
    amt = int'(imm) % w;
    for (int i = 0; i < 256; i++) begin
      pos  = i % w;
      base = i - pos;
      case (sel)
        2'b11:   o[i] = (pos >= amt) ? a[i-amt] : 1'b0;
        2'b00:   o[i] = (pos + amt < w) ? a[i+amt] : 1'b0;
        2'b01:   o[i] = (pos + amt < w) ? a[i+amt] : a[base+w-1];
        default: o[i] = 1'b0;
      endcase
    end
    return o;
  endfunction

  assign sh_out = shift_model(sh_a, sh_mode, sh_sel, sh_imm);

  task automatic send(input logic [2:0] op, input logic [2:0] mode,
                      input logic [255:0] a, input logic [7:0] amt);
    cmd_op = op; cmd_mode = mode; cmd_a = a; cmd_amt = amt; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = 1;
    while (!res_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!res_valid) lat = -1;
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 3'b011; cmd_mode = 3'd0;
    cmd_a = '1; cmd_amt = 8'd1; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tot++; if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_idle: cmd_ready=%b busy=%b want 1 0", cmd_ready, busy); else n_pass++;
    n_tot++; if (res_valid !== 1'b0 || res_err !== 1'b0) $display("FAIL reset_res: res_valid=%b res_err=%b want 0 0", res_valid, res_err); else n_pass++;
    n_tot++; if (res_data !== 256'h0) $display("FAIL reset_data: got %h want 0", res_data); else n_pass++;
    n_tot++; if (sh_sel !== 2'b10 || sh_a !== 256'h0 || sh_imm !== 8'h0) $display("FAIL reset_sh: sel=%b imm=%h want 10 00", sh_sel, sh_imm); else n_pass++;
    rst = 1'b0; cmd_valid = 1'b0;
    @(posedge clk); #1;
    n_tot++; if (busy !== 1'b0) $display("FAIL reset_no_accept: busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_sll();
    int lat;
    logic [255:0] a, exp_d;
    a = {32{8'h81}}; exp_d = {32{8'h08}};
    send(3'b011, 3'd0, a, 8'd3);
    n_tot++; if (sh_sel !== 2'b11 || sh_imm !== 8'd3 || sh_a !== a) $display("FAIL sll_pass1_drive: sel=%b imm=%h want 11 03", sh_sel, sh_imm); else n_pass++;
    n_tot++; if (sh_b !== 256'h0 || sh_imm_flag !== 1'b1 || sh_mode !== 3'd0) $display("FAIL sll_const: flag=%b mode=%0d want 1 0", sh_imm_flag, sh_mode); else n_pass++;
    n_tot++; if (busy !== 1'b1 || cmd_ready !== 1'b0) $display("FAIL sll_busy: busy=%b cmd_ready=%b want 1 0", busy, cmd_ready); else n_pass++;
    wait_res(lat);
    n_tot++; if (lat !== 2) $display("FAIL sll_latency: got %0d want 2", lat); else n_pass++;
    n_tot++; if (res_data !== exp_d || res_err !== 1'b0) $display("FAIL sll_data: got %h err=%b want %h err=0", res_data, res_err, exp_d); else n_pass++;
    consume();
    n_tot++; if (busy !== 1'b0 || res_valid !== 1'b0) $display("FAIL sll_release: busy=%b res_valid=%b want 0 0", busy, res_valid); else n_pass++;
  endtask

  task automatic test_sra();
    int lat;
    logic [255:0] exp_d;
    exp_d = {16{16'hF800}};
    send(3'b001, 3'd1, {16{16'h8000}}, 8'd4);
    n_tot++; if (sh_sel !== 2'b01) $display("FAIL sra_sel: got %b want 01", sh_sel); else n_pass++;
    wait_res(lat);
    n_tot++; if (lat !== 2) $display("FAIL sra_latency: got %0d want 2", lat); else n_pass++;
    n_tot++; if (res_data !== exp_d || res_err !== 1'b0) $display("FAIL sra_data: got %h err=%b want %h err=0", res_data, res_err, exp_d); else n_pass++;
    consume();
  endtask

  task automatic test_rol();
    int lat, exp_lat;
    logic [255:0] exp_d;
    logic exp_e;
`ifdef SIMD_SHIFT_CTRL_ROTATE_EN
    exp_lat = 3; exp_d = {8{32'h00000003}}; exp_e = 1'b0;
`else
    exp_lat = 1; exp_d = '0; exp_e = 1'b1;
`endif
    send(3'b100, 3'd2, {8{32'h80000001}}, 8'd1);
    wait_res(lat);
    n_tot++; if (lat !== exp_lat) $display("FAIL rol_latency: got %0d want %0d", lat, exp_lat); else n_pass++;
    n_tot++; if (res_data !== exp_d || res_err !== exp_e) $display("FAIL rol_data: got %h err=%b want %h err=%b", res_data, res_err, exp_d, exp_e); else n_pass++;
    consume();
  endtask

  task automatic test_ror();
    int lat, exp_lat;
    logic [255:0] exp0, exp1;
    logic exp_e;
`ifdef SIMD_SHIFT_CTRL_ROTATE_EN
    exp_lat = 3; exp0 = 256'h1; exp1 = 256'h1 << 255; exp_e = 1'b0;
`else
    exp_lat = 1; exp0 = '0; exp1 = '0; exp_e = 1'b1;
`endif
    send(3'b101, 3'd5, 256'h1, 8'd0);
    wait_res(lat);
    n_tot++; if (lat !== exp_lat) $display("FAIL ror0_latency: got %0d want %0d", lat, exp_lat); else n_pass++;
    n_tot++; if (res_data !== exp0 || res_err !== exp_e) $display("FAIL ror0_data: got %h err=%b want %h err=%b", res_data, res_err, exp0, exp_e); else n_pass++;
    consume();
    send(3'b101, 3'd5, 256'h1, 8'd1);
    wait_res(lat);
    n_tot++; if (res_data !== exp1 || res_err !== exp_e) $display("FAIL ror1_data: got %h err=%b want %h err=%b", res_data, res_err, exp1, exp_e); else n_pass++;
    consume();
  endtask

  task automatic test_illegal_hold();
    int lat;
    send(3'b010, 3'd0, '1, 8'd1);
    wait_res(lat);
    n_tot++; if (lat !== 1) $display("FAIL illegal_latency: got %0d want 1", lat); else n_pass++;
    n_tot++; if (res_data !== 256'h0 || res_err !== 1'b1) $display("FAIL illegal_data: got %h err=%b want 0 err=1", res_data, res_err); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      cmd_op = 3'b011; cmd_mode = 3'd1; cmd_a = '1; cmd_amt = 8'd2; cmd_valid = 1'b1;
      @(posedge clk); #1;
      n_tot++; if (res_valid !== 1'b1 || res_data !== 256'h0 || res_err !== 1'b1 || cmd_ready !== 1'b0)
        $display("FAIL illegal_hold%0d: valid=%b err=%b ready=%b want 1 1 0", k, res_valid, res_err, cmd_ready); else n_pass++;
    end
    cmd_valid = 1'b0;
    consume();
    n_tot++; if (busy !== 1'b0) $display("FAIL illegal_release: busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat;
    send(3'b011, 3'd0, {32{8'h81}}, 8'd3);
    wait_res(lat);
    cmd_op = 3'b000; cmd_mode = 3'd3; cmd_a = 256'hF0; cmd_amt = 8'd4; cmd_valid = 1'b1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    n_tot++; if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL b2b_no_accept_on_release: ready=%b busy=%b want 1 0", cmd_ready, busy); else n_pass++;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_tot++; if (busy !== 1'b1) $display("FAIL b2b_accept: busy=%b want 1", busy); else n_pass++;
    wait_res(lat);
    n_tot++; if (lat !== 2 || res_data !== 256'h0F) $display("FAIL b2b_srl: lat=%0d data=%h want 2 0f", lat, res_data); else n_pass++;
    consume();
  endtask

  task automatic test_rst_midflight();
    bit seen;
`ifdef SIMD_SHIFT_CTRL_ROTATE_EN
    send(3'b100, 3'd2, {8{32'h80000001}}, 8'd1);
    @(posedge clk); #1;
    n_tot++; if (sh_imm !== 8'd31 || sh_sel !== 2'b00) $display("FAIL rst_pass2_drive: imm=%0d sel=%b want 31 00", sh_imm, sh_sel); else n_pass++;
`else
    send(3'b011, 3'd0, {32{8'h81}}, 8'd3);
    n_tot++; if (sh_sel !== 2'b11) $display("FAIL rst_pass1_drive: sel=%b want 11", sh_sel); else n_pass++;
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tot++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0)
      $display("FAIL rst_mid_idle: ready=%b busy=%b valid=%b want 1 0 0", cmd_ready, busy, res_valid); else n_pass++;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (res_valid) seen = 1'b1;
    end
    n_tot++; if (seen !== 1'b0) $display("FAIL rst_mid_no_result: res_valid seen=%b want 0", seen); else n_pass++;
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_op = '0; cmd_mode = '0; cmd_a = '0; cmd_amt = '0;
    res_ready = 1'b0; rst = 1'b1;
    test_reset();
    test_sll();
    test_sra();
    test_rol();
    test_ror();
    test_illegal_hold();
    test_back_to_back();
    test_rst_midflight();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/simd_shift_ctrl.md
SIMD_SHIFT_CTRL -- requirements
Module: simd_shift_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the single clock and rst is the synchronous active-high reset.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_op  in  3  operation: 000 SRL, 001 SRA, 011 SLL, 100 ROL, 101 ROR; others illegal
- cmd_mode  in  3  lane width: 0..4 give 8/16/32/64/128 bits; 5..7 give 256 bits
- cmd_a  in  256  operand
- cmd_amt  in  8  shift/rotate amount
- res_valid  out  1  result available
- res_ready  in  1  result consumed when high with res_valid
- res_data  out  256  result
- res_err  out  1  illegal op flag, qualified by res_valid
- busy  out  1  state not IDLE
- sh_a  out  256  shifter operand
- sh_b  out  256  shifter B, constant 0
- sh_mode  out  3  shifter data_mode
- sh_sel  out  2  shifter sel
- sh_imm_flag  out  1  constant 1
- sh_imm  out  8  shifter immediate amount
- sh_out  in  256  combinational shifter result

Function
REQ-003 The FSM SHALL have states IDLE, PASS1, PASS2 and OUT; cmd_ready SHALL be 1 only in IDLE.
REQ-004 On cmd_valid&cmd_ready the block SHALL register op, mode, a and amt, then go to PASS1 for a legal op or to OUT for an illegal op.
REQ-005 For an illegal op the block SHALL set res_data=0 and res_err=1, with res_valid high in the cycle after acceptance.
REQ-006 In PASS1 the block SHALL drive sh_a=a, sh_mode=mode and sh_imm=amt, with sh_sel as follows:
- SRL: 00
- SRA: 01
- SLL: 11
- ROL: 11
- ROR: 00
REQ-007 At the end of PASS1 the block SHALL capture sh_out into an internal partial register.
REQ-008 After PASS1, SRL, SRA and SLL SHALL go to OUT with res_data=partial and res_err=0, so res_valid is high 2 cycles after acceptance.
REQ-009 After PASS1, ROL and ROR SHALL go to PASS2.
REQ-010 In PASS2 the block SHALL use lane width w=8<<mode (256 for mode>=5) and n=amt mod w, and SHALL drive:
- sh_a=a
- sh_imm=(w-n) mod w, truncated to 8 bits
- sh_sel=00 for ROL, 11 for ROR
REQ-011 At the end of PASS2, res_data SHALL be loaded with partial|sh_out, so rotate latency is 3 cycles and n=0 returns a unchanged.
REQ-012 In OUT the block SHALL hold res_valid, res_data and res_err stable until res_ready=1, then return to IDLE in the next cycle.
REQ-013 No new command SHALL be accepted in the cycle res_valid&res_ready is sampled; back-to-back throughput SHALL therefore be one command per 3 (shift) or 4 (rotate) cycles.
REQ-014 Outside PASS1 and PASS2 the block SHALL drive sh_sel=10 (shifter NOP), sh_a=0 and sh_imm=0.
REQ-015 The cmd_* inputs SHALL be ignored in every state except IDLE.
REQ-016 busy SHALL equal (state!=IDLE).

Reset
REQ-017 When rst=1 at a clock edge, the block SHALL enter IDLE and set res_valid=0, res_data=0, res_err=0, busy=0 and cmd_ready=1.
REQ-018 A reset in PASS1, PASS2 or OUT SHALL discard the in-flight command with no result produced.
REQ-019 When rst and cmd_valid are high in the same cycle, reset SHALL take precedence and the command SHALL not be accepted.

Configuration
REQ-020 Macro SIMD_SHIFT_CTRL_ROTATE_EN SHALL control rotate support:
- Defined: ROL and ROR behave per REQ-009 to REQ-011.
- Undefined: PASS2 and its logic are absent, and ops 100 and 101 are treated as illegal per REQ-005.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- SLL, mode 0, a=all 0x81 bytes, amt=3 -> res_data all bytes 0x08, res_err=0, res_valid 2 cycles after accept.
- SRA, mode 1, a=all 0x8000 halfwords, amt=4 -> all halfwords 0xF800.
- ROL, mode 2, a=all words 0x80000001, amt=1, macro defined -> all words 0x00000003, res_valid 3 cycles after accept; same stimulus with macro undefined -> res_err=1, res_data=0, res_valid 1 cycle after accept.
- ROR, mode 5, a=1, amt=0 -> res_data=1; ROR, mode 5, a=1, amt=1 -> only bit 255 set.
- cmd_op=010 -> res_err=1, res_data=0; hold res_ready=0 for 5 cycles -> outputs stable, cmd_ready=0 throughout.
- rst asserted in PASS2 -> next cycle IDLE, res_valid=0, cmd_ready=1, and no result is ever emitted for that command.
